ultrasonic_ranger: RTL and testbench
====================================

# ultrasonic_ranger

Multi-channel, parametrised controller for HC-SR04-class ultrasonic range sensors on the GPIO header. It fires each channel's trigger in round-robin order and times the returned echo pulse. It converts the echo width to centimetres on the fly, with no divider, and flags no-echo and over-range results. Per-channel results and valid strobes feed the board's BCD/seven-segment display path.

## Interface
- CHANNELS, 2, number of sensors, at least 1; channels are fired one at a time
- TRIG_CYCLES, 500, trigger pulse width in clocks (10 us at 50 MHz)
- CYCLES_PER_CM, 2900, echo-high clocks per centimetre (58 us at 50 MHz)
- TIMEOUT_CYCLES, 1900000, maximum wait for echo rise, and maximum echo-high time (38 ms)
- PERIOD_CYCLES, 4194304, slot length per channel, measured from trigger rise; must be at least TRIG_CYCLES + 2*TIMEOUT_CYCLES + 8
- WIDTH, 14, result width in bits
- OOR_VALUE, 9999, result reported on timeout; must fit in WIDTH bits

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  start and continue measurement cycles
- echo  in  CHANNELS  raw echo pins; asynchronous to the clock
- trig  out  CHANNELS  trigger pins; one-hot or zero
- distance  out  CHANNELS*WIDTH  latest result per channel in cm; channel n occupies [n*WIDTH +: WIDTH]
- valid  out  CHANNELS  one-cycle strobe when that channel's distance updates
- timeout  out  CHANNELS  1 if that channel's latest result was a timeout
- active_ch  out  clog2(CHANNELS), minimum 1  channel currently owning the slot

## Operation
- Each echo bit passes through a 2-FF synchronizer. Edge detection uses the synchronized value and its 1-cycle delayed copy.
- Counters: slot counter, timeout counter, sub-cm prescaler (0..CYCLES_PER_CM-1), cm counter (WIDTH bits).
- IDLE: trig=0. Leave when enable=1, go to TRIG for channel active_ch, clear slot counter.
- TRIG: trig[active_ch]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE and clear the timeout counter. Echo edges seen during TRIG are ignored.
- WAIT_RISE: wait for a synchronized rising edge on echo[active_ch]. A level already high on entry is not a rise. On a rise, go to ECHO and clear the prescaler, cm counter and timeout counter. If the timeout counter reaches TIMEOUT_CYCLES, go to RESULT with a timeout.
- ECHO: count each cycle the synchronized echo is high. When the prescaler wraps at CYCLES_PER_CM-1, the cm counter increments, saturating at OOR_VALUE-1.
  - Synchronized falling edge: go to RESULT with the cm value; the fraction is truncated.
  - Timeout counter reaches TIMEOUT_CYCLES: go to RESULT with a timeout.
- RESULT (1 cycle):
  - Write distance[active_ch] = cm value, or OOR_VALUE on timeout.
  - Set timeout[active_ch] accordingly.
  - Pulse valid[active_ch].
  - Go to HOLD.
- HOLD: wait until the slot counter reaches PERIOD_CYCLES-1. Then active_ch advances, wrapping from CHANNELS-1 to 0. Next state is TRIG if enable=1, else IDLE.
- Deasserting enable mid-slot does not abort: the current measurement completes and its result is posted.
- Other channels' echoes are ignored outside their own slot.

## Timing
- Reset values: trig=0, distance=0, valid=0, timeout=0, active_ch=0, state IDLE. Synchronizers and all counters clear.
- Reset asserted mid-operation drops trig combinationally-free: trig is a register, cleared asynchronously.
- First trigger: trig[0] rises on the first CLOCK_50 edge with reset low and enable high, sampled in IDLE.
- Echo pin to internal edge latency: 3 cycles (2 synchronizer stages, then edge register).
- Result latency: valid rises 4 cycles after the echo pin falls. Distance and timeout update on the same edge as valid.
- Back-to-back slots: trigger rises are exactly PERIOD_CYCLES apart, measured from TRIG entry.
- Single-channel operation (CHANNELS=1) repeats channel 0; active_ch stays 0.
- Echo exactly N*CYCLES_PER_CM clocks high (synchronized) gives result N.

## Test plan
All scenarios use CHANNELS=2, TRIG_CYCLES=4, CYCLES_PER_CM=10, TIMEOUT_CYCLES=200, PERIOD_CYCLES=600.
- Normal: echo[0] rises 20 cycles after trig[0] falls and stays high 105 cycles -> one valid[0] pulse 4 cycles after the fall, distance[0]=10, timeout[0]=0, trig[0] high exactly 4 cycles.
- No echo: echo[1] held low -> 200 cycles after trig[1] falls, distance[1]=9999, timeout[1]=1, valid[1] pulses once; distance[0] is unchanged.
- Stuck echo: echo[0] held high from before trigger and through the slot -> no rise is detected, so the result is a timeout with distance[0]=9999. A later clean 55-cycle echo gives distance[0]=5 and timeout[0]=0.
- Round-robin and period: enable held high -> trig[0] rises at t0, trig[1] at t0+600, trig[0] at t0+1200; active_ch is 0,1,0; trig is never more than one bit hot.
- Reset mid-echo: assert reset 50 cycles into an echo pulse -> trig=0, distance=0, valid=0, timeout=0 immediately. After release, trig[0] is the first trigger, and no stale valid is produced.
- Enable drop: deassert enable during ECHO of channel 0 -> the result is still posted with a valid[0] pulse, then trig stays 0 and active_ch=1. Re-asserting enable fires trig[1].

Source files
------------

// File: rtl/ultrasonic_ranger_if.sv
// Signal bundle between the ranging controller and the sensor/display side:
// run control, raw echo pins, trigger pins and per-channel results.
interface ultrasonic_ranger_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 14
);
    localparam int unsigned ACW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      enable;
    logic [CHANNELS-1:0]       echo;
    logic [CHANNELS-1:0]       trig;
    logic [CHANNELS*WIDTH-1:0] distance;
    logic [CHANNELS-1:0]       valid;
    logic [CHANNELS-1:0]       timeout;
    logic [ACW-1:0]            active_ch;

    modport master (
        input  enable,
        input  echo,
        output trig,
        output distance,
        output valid,
        output timeout,
        output active_ch
    );

    modport slave (
        output enable,
        output echo,
        input  trig,
        input  distance,
        input  valid,
        input  timeout,
        input  active_ch
    );
endinterface

// File: rtl/ultrasonic_ranger.sv
// Round-robin HC-SR04 ranging controller: one trigger per slot, echo timed and
// converted to centimetres with a sub-cm prescaler so no divider is needed.
module ultrasonic_ranger #(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned CYCLES_PER_CM  = 2900,
    parameter int unsigned TIMEOUT_CYCLES = 1900000,
    parameter int unsigned PERIOD_CYCLES  = 4194304,
    parameter int unsigned WIDTH          = 14,
    parameter int unsigned OOR_VALUE      = 9999
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    ultrasonic_ranger_if.master bus
);
    localparam int unsigned ACW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned SLOT_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PRE_W   = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TRIG   = 3'd1,
        S_WAIT   = 3'd2,
        S_ECHO   = 3'd3,
        S_RESULT = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t                    r_state;
    logic [CHANNELS-1:0]       r_sync1;
    logic [CHANNELS-1:0]       r_sync2;
    logic [CHANNELS-1:0]       r_sync_d;
    logic [ACW-1:0]            r_ch;
    logic [SLOT_W-1:0]         r_slot;
    logic [CNT_W-1:0]          r_cnt;
    logic [PRE_W-1:0]          r_pre;
    logic [WIDTH-1:0]          r_cm;
    logic                      r_tmo_hit;
    logic [CHANNELS-1:0]       r_trig;
    logic [CHANNELS-1:0]       r_valid;
    logic [CHANNELS-1:0]       r_timeout;
    logic [CHANNELS*WIDTH-1:0] r_dist;

    logic                      w_echo_cur;
    logic                      w_echo_dly;
    logic                      w_rise;
    logic                      w_fall;
    logic                      w_slot_end;
    logic                      w_tmo_end;
    logic                      w_trig_end;
    logic                      w_pre_wrap;
    logic                      w_cm_sat;
    logic [ACW-1:0]            w_ch_next;
    logic [CHANNELS-1:0]       w_sel_cur;
    logic [CHANNELS-1:0]       w_sel_next;

    // Two-stage synchronizer plus a delayed copy for edge detection
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync1  <= bus.echo;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_echo_cur = r_sync2[r_ch];
    assign w_echo_dly = r_sync_d[r_ch];
    assign w_rise     = w_echo_cur & ~w_echo_dly;
    assign w_fall     = ~w_echo_cur & w_echo_dly;

    assign w_slot_end = (r_slot == SLOT_W'(PERIOD_CYCLES - 1));
    assign w_tmo_end  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_trig_end = (r_cnt == CNT_W'(TRIG_CYCLES - 1));
    assign w_pre_wrap = (r_pre == PRE_W'(CYCLES_PER_CM - 1));
    assign w_cm_sat   = (r_cm == WIDTH'(OOR_VALUE - 1));

    assign w_ch_next  = (r_ch == ACW'(CHANNELS - 1)) ? '0 : r_ch + ACW'(1);
    assign w_sel_cur  = CHANNELS'(1) << r_ch;
    assign w_sel_next = CHANNELS'(1) << w_ch_next;

    // Measurement sequencer; the delayed echo copy is what gets counted so that
    // every synchronized high cycle lands inside ECHO, including the falling one.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ch      <= '0;
            r_slot    <= '0;
            r_cnt     <= '0;
            r_pre     <= '0;
            r_cm      <= '0;
            r_tmo_hit <= 1'b0;
            r_trig    <= '0;
            r_valid   <= '0;
            r_timeout <= '0;
            r_dist    <= '0;
        end else begin
            r_valid <= '0;
            if (r_state != S_IDLE) begin
                r_slot <= r_slot + SLOT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_state <= S_TRIG;
                        r_trig  <= w_sel_cur;
                        r_cnt   <= '0;
                        r_slot  <= '0;
                    end
                end

                S_TRIG: begin
                    if (w_trig_end) begin
                        r_trig  <= '0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_WAIT: begin
                    if (w_rise) begin
                        r_state   <= S_ECHO;
                        r_cnt     <= '0;
                        r_pre     <= '0;
                        r_cm      <= '0;
                        r_tmo_hit <= 1'b0;
                    end else if (w_tmo_end) begin
                        r_state   <= S_RESULT;
                        r_tmo_hit <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_ECHO: begin
                    if (w_echo_dly) begin
                        if (w_pre_wrap) begin
                            r_pre <= '0;
                            if (!w_cm_sat) begin
                                r_cm <= r_cm + WIDTH'(1);
                            end
                        end else begin
                            r_pre <= r_pre + PRE_W'(1);
                        end
                    end
                    if (w_fall) begin
                        r_state   <= S_RESULT;
                        r_tmo_hit <= 1'b0;
                    end else if (w_tmo_end) begin
                        r_state   <= S_RESULT;
                        r_tmo_hit <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_RESULT: begin
                    r_dist[r_ch*WIDTH +: WIDTH] <= r_tmo_hit ? WIDTH'(OOR_VALUE) : r_cm;
                    r_timeout[r_ch]             <= r_tmo_hit;
                    r_valid                     <= w_sel_cur;
                    r_state                     <= S_HOLD;
                end

                S_HOLD: begin
                    if (w_slot_end) begin
                        r_ch <= w_ch_next;
                        if (bus.enable) begin
                            r_state <= S_TRIG;
                            r_trig  <= w_sel_next;
                            r_cnt   <= '0;
                            r_slot  <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_trig  <= '0;
                end
            endcase
        end
    end

    assign bus.trig      = r_trig;
    assign bus.distance  = r_dist;
    assign bus.valid     = r_valid;
    assign bus.timeout   = r_timeout;
    assign bus.active_ch = r_ch;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed + randomized bench for ultrasonic_ranger; expected results come from
// a slot-level model (echo width / cm, timeout rules, round-robin schedule).
module tb_ultrasonic_ranger;
    localparam int unsigned CH   = 2;
    localparam int unsigned TRIG = 4;
    localparam int unsigned CPC  = 10;
    localparam int unsigned TMO  = 200;
    localparam int unsigned PER  = 600;
    localparam int unsigned W    = 14;
    localparam int unsigned OOR  = 9999;

    logic clk = 1'b0;
    logic rst;

    ultrasonic_ranger_if #(.CHANNELS(CH), .WIDTH(W)) u_if ();

    ultrasonic_ranger #(
        .CHANNELS      (CH),
        .TRIG_CYCLES   (TRIG),
        .CYCLES_PER_CM (CPC),
        .TIMEOUT_CYCLES(TMO),
        .PERIOD_CYCLES (PER),
        .WIDTH         (W),
        .OOR_VALUE     (OOR)
    ) u_dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (u_if)
    );

    always #5 clk = ~clk;

    int n_chk;
    int n_fail;
    int cyc;
    int vcnt [CH];
    int trig_rises;
    int onehot_err;
    logic [CH-1:0] trig_q = '0;

    int unsigned m_dist [CH];
    bit          m_tmo  [CH];

    always @(posedge clk) cyc <= cyc + 1;

    // Observers: valid pulses per channel, trigger rises, one-hot violations
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (u_if.valid[c]) vcnt[c]++;
        end
        if ((u_if.trig & ~trig_q) != '0) trig_rises++;
        if ((u_if.trig & (u_if.trig - 1'b1)) != '0) onehot_err++;
        trig_q = u_if.trig;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [CH-1:0] onehot(input int ch);
        logic [CH-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

    function automatic logic [CH*W-1:0] pack_dist();
        logic [CH*W-1:0] v;
        for (int c = 0; c < CH; c++) v[c*W +: W] = W'(m_dist[c]);
        return v;
    endfunction

    function automatic logic [CH-1:0] pack_tmo();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_tmo[c];
        return v;
    endfunction

    // Expected outcome of an echo held high for h synchronized cycles
    task automatic model_echo(input int ch, input int h);
        if (h > int'(TMO)) begin
            m_dist[ch] = OOR;
            m_tmo[ch]  = 1'b1;
        end else begin
            m_dist[ch] = (h / CPC > OOR - 1) ? OOR - 1 : h / CPC;
            m_tmo[ch]  = 1'b0;
        end
    endtask

    task automatic wait_trig(input int budget, output int t);
        int n;
        n = 0;
        while (u_if.trig == '0 && n < budget) begin
            tick(1);
            n++;
        end
        check("trig_rise_seen", (u_if.trig != '0), 1);
        t = cyc;
    endtask

    task automatic wait_valid(input int ch, input int budget, output int lat);
        lat = 0;
        while (!u_if.valid[ch] && lat < budget) begin
            tick(1);
            lat++;
        end
        check("valid_seen", u_if.valid[ch], 1);
    endtask

    task automatic trig_width(input int ch);
        int w;
        w = 0;
        while (u_if.trig[ch] && w < 50) begin
            w++;
            tick(1);
        end
        check("trig_width", w, TRIG);
    endtask

    // One slot, starting at the sample just after trig rises.
    // h == 0 means no echo; noise also pulses every other channel's echo.
    task automatic do_measure(input int ch, input int d, input int h, input bit noise);
        int lat;
        int vb [CH];
        logic [CH-1:0] e;
        trig_width(ch);
        for (int c = 0; c < CH; c++) vb[c] = vcnt[c];
        if (h == 0) begin
            wait_valid(ch, TMO + 20, lat);
            check("no_echo_latency", (lat >= int'(TMO) && lat <= int'(TMO) + 2), 1);
            m_dist[ch] = OOR;
            m_tmo[ch]  = 1'b1;
        end else begin
            tick(d);
            e = noise ? '1 : onehot(ch);
            u_if.echo = u_if.echo | e;
            model_echo(ch, h);
            if (h <= int'(TMO)) begin
                tick(h);
                u_if.echo = '0;
                tick(3);
                check("valid_early", u_if.valid, 0);
                tick(1);
                check("valid_strobe", u_if.valid, onehot(ch));
            end else begin
                wait_valid(ch, TMO + 20, lat);
                check("long_echo_latency", (lat >= int'(TMO) + 2 && lat <= int'(TMO) + 6), 1);
                u_if.echo = '0;
            end
        end
        check("distance", u_if.distance, pack_dist());
        check("timeout", u_if.timeout, pack_tmo());
        tick(1);
        for (int c = 0; c < CH; c++) begin
            check(c == ch ? "valid_once" : "other_valid_quiet", vcnt[c] - vb[c], (c == ch) ? 1 : 0);
        end
    endtask

    initial begin
        int t_prev, t_now, exp_ch, d, h, sel, lat, vsum, tr;
        bit noise;

        rst = 1'b1;
        u_if.enable = 1'b0;
        u_if.echo = '0;
        for (int c = 0; c < CH; c++) begin
            m_dist[c] = 0;
            m_tmo[c]  = 1'b0;
        end
        tick(3);
        check("reset_trig", u_if.trig, 0);
        check("reset_distance", u_if.distance, 0);
        check("reset_valid", u_if.valid, 0);
        check("reset_timeout", u_if.timeout, 0);
        check("reset_active_ch", u_if.active_ch, 0);

        rst = 1'b0;
        tick(5);
        check("idle_no_trig", u_if.trig, 0);

        // Normal echo on channel 0
        u_if.enable = 1'b1;
        wait_trig(5, t_prev);
        check("first_trig", u_if.trig, onehot(0));
        check("active_ch_0", u_if.active_ch, 0);
        do_measure(0, 20, 105, 1'b0);

        // No echo on channel 1; channel 0 result must survive
        wait_trig(PER + 5, t_now);
        check("period_01", t_now - t_prev, PER);
        check("trig_ch1", u_if.trig, onehot(1));
        check("active_ch_1", u_if.active_ch, 1);
        do_measure(1, 0, 0, 1'b0);

        // Stuck-high echo on channel 0: level present before WAIT_RISE is not a rise
        u_if.echo[0] = 1'b1;
        t_prev = t_now;
        wait_trig(PER + 5, t_now);
        check("period_10", t_now - t_prev, PER);
        check("active_ch_wrap", u_if.active_ch, 0);
        trig_width(0);
        wait_valid(0, TMO + 20, lat);
        check("stuck_latency", (lat >= int'(TMO) && lat <= int'(TMO) + 2), 1);
        m_dist[0] = OOR;
        m_tmo[0]  = 1'b1;
        check("stuck_distance", u_if.distance, pack_dist());
        check("stuck_timeout", u_if.timeout, pack_tmo());
        u_if.echo[0] = 1'b0;

        // Directed boundaries then randomized slots
        exp_ch = 1;
        for (int s = 0; s < 11; s++) begin
            t_prev = t_now;
            wait_trig(PER + 5, t_now);
            check("period", t_now - t_prev, PER);
            check("active_ch_rr", u_if.active_ch, exp_ch);
            check("trig_onehot_ch", u_if.trig, onehot(exp_ch));
            noise = 1'b0;
            if (s == 0) begin
                d = 7;  h = TMO;
            end else if (s == 1) begin
                d = 20; h = 55;
            end else if (s == 2) begin
                d = 5;  h = TMO + 30;
            end else begin
                d = $urandom_range(1, 150);
                sel = $urandom_range(0, 9);
                if (sel == 0) h = 0;
                else if (sel == 1) h = $urandom_range(TMO + 1, TMO + 40);
                else h = $urandom_range(1, TMO);
                noise = 1'($urandom_range(0, 1));
            end
            do_measure(exp_ch, d, h, noise);
            exp_ch = (exp_ch + 1) % CH;
        end

        // Reset in the middle of an echo pulse
        wait_trig(PER + 5, t_now);
        trig_width(exp_ch);
        tick(10);
        u_if.echo = onehot(exp_ch);
        tick(50);
        rst = 1'b1;
        #1;
        check("rst_trig", u_if.trig, 0);
        check("rst_distance", u_if.distance, 0);
        check("rst_valid", u_if.valid, 0);
        check("rst_timeout", u_if.timeout, 0);
        check("rst_active_ch", u_if.active_ch, 0);
        for (int c = 0; c < CH; c++) begin
            m_dist[c] = 0;
            m_tmo[c]  = 1'b0;
        end
        vsum = vcnt[0] + vcnt[1];
        u_if.echo = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("post_rst_trig", u_if.trig, onehot(0));
        check("post_rst_active", u_if.active_ch, 0);

        // Enable dropped during channel 0's echo: result still posted, then idle
        trig_width(0);
        tick(10);
        u_if.echo = onehot(0);
        tick(30);
        u_if.enable = 1'b0;
        tick(50);
        u_if.echo = '0;
        model_echo(0, 80);
        tick(3);
        check("drop_valid_early", u_if.valid, 0);
        tick(1);
        check("drop_valid", u_if.valid, onehot(0));
        check("drop_distance", u_if.distance, pack_dist());
        check("drop_timeout", u_if.timeout, pack_tmo());
        check("no_stale_valid", vcnt[0] + vcnt[1] - vsum, 0);
        tick(1);
        tr = trig_rises;
        tick(PER);
        check("drop_no_retrigger", trig_rises - tr, 0);
        check("drop_trig_low", u_if.trig, 0);
        check("drop_active_ch", u_if.active_ch, 1);
        u_if.enable = 1'b1;
        tick(1);
        check("reenable_trig", u_if.trig, onehot(1));

        check("trig_never_multi_hot", onehot_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
